// File: rtl/jk_drive_ctrl.sv
// Command sequencer feeding a JK flip-flop: drives j/k for N cycles, then checks q against a model.
// Optional JK_DRV_COMPL_CHECK_EN also checks that qbar is the complement of q.
module jk_drive_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCheck
  } state_e;

  localparam logic [1:0] OpHold   = 2'b00;
  localparam logic [1:0] OpClear  = 2'b01;
  localparam logic [1:0] OpSet    = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

  state_e           state;
  logic [CNT_W-1:0] cnt_eff;
  logic             exp_next;
  logic             check_fail;

  assign cmd_ready = (state == StIdle) && !rst;

  // A zero count still drives the flip-flop once.
  assign cnt_eff = (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;

  always_comb begin
    exp_next = q_in;
    unique case (cmd_op)
      OpHold:   exp_next = q_in;
      OpClear:  exp_next = 1'b0;
      OpSet:    exp_next = 1'b1;
      OpToggle: exp_next = q_in ^ cnt_eff[0];
      default:  exp_next = q_in;
    endcase
  end

`ifdef JK_DRV_COMPL_CHECK_EN
  logic compl_seen;

  assign check_fail = (q_in != exp_q) || (qbar_in == q_in);
`else
  logic unused_qbar;

  assign unused_qbar = qbar_in;
  assign check_fail  = (q_in != exp_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      j          <= 1'b0;
      k          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      exp_q      <= 1'b0;
      mismatch   <= 1'b0;
      remaining  <= '0;
`ifdef JK_DRV_COMPL_CHECK_EN
      compl_seen <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          j <= 1'b0;
          k <= 1'b0;
`ifdef JK_DRV_COMPL_CHECK_EN
          // qbar equal to q on two consecutive idle edges flags a broken complement.
          if (qbar_in == q_in) begin
            if (compl_seen) mismatch <= 1'b1;
            compl_seen <= 1'b1;
          end else begin
            compl_seen <= 1'b0;
          end
`endif
          if (cmd_valid) begin
            remaining <= cnt_eff;
            j         <= cmd_op[1];
            k         <= cmd_op[0];
            busy      <= 1'b1;
            exp_q     <= exp_next;
            state     <= StDrive;
          end
        end
        StDrive: begin
`ifdef JK_DRV_COMPL_CHECK_EN
          compl_seen <= 1'b0;
`endif
          if (remaining == CNT_W'(1)) begin
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b1;
            state     <= StCheck;
          end else begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        StCheck: begin
`ifdef JK_DRV_COMPL_CHECK_EN
          compl_seen <= 1'b0;
`endif
          mismatch <= check_fail;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
